// File: rtl/fsmc_tx_fifo.sv
// fsmc_tx_fifo: sink stage behind the FSMC bus interface.
//   - cs_data write cycles push bus words into a DEPTH-entry FIFO.
//   - cs_stat write cycles hit a control register (bit0 flush, bit1 clear overflow).
//   - Reads on either chip select are side-effect free and return the status word,
//     or zero while the data slot is selected.
//   - The FIFO drains over a first-word fall-through valid/ready stream.
// Optional feature: define FSMC_TX_FIFO_IRQ_EN to add the registered level
// interrupt port irq (almost_full | overflow).
//
// Stream handshake: m_valid is high whenever the FIFO holds at least one word,
// and m_data is then the head word. A word transfers on every rising clk edge
// where m_valid & m_ready. While m_valid is high and m_ready is low, m_data and
// m_valid hold. m_valid never depends combinationally on m_ready.
module fsmc_tx_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 64,
  parameter int AF_THRESHOLD = 48
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bus_wdata,
  input  logic                  bus_state,
  input  logic                  cs_data,
  input  logic                  cs_stat,
  output logic [DATA_WIDTH-1:0] bus_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready
`ifdef FSMC_TX_FIFO_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LEVEL_AF   = LW'(AF_THRESHOLD);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);

  // Status word seen right after reset: only the empty flag is set.
  localparam logic [DATA_WIDTH-1:0] STAT_RESET = DATA_WIDTH'(16'h2000);

  // Storage; contents are deliberately not reset.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr, wr_ptr_nxt;
  logic [PW-1:0] rd_ptr, rd_ptr_nxt;
  logic [LW-1:0] level, level_nxt;
  logic          overflow, overflow_nxt;

  // Previous chip-select levels for falling-edge (end of access) detection.
  logic prev_cs_data;
  logic prev_cs_stat;

  logic wr_strobe;
  logic ctl_strobe;
  logic flush;
  logic ovf_clr;
  logic full;
  logic pop;
  logic push_req;
  logic push;
  logic drop;

  logic                  full_nxt;
  logic                  empty_nxt;
  logic                  af_nxt;
  logic [11:0]           level_field;
  logic [DATA_WIDTH-1:0] stat_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;

  // Strobes fire on the cycle a chip select is released after a write access.
  always_comb begin
    wr_strobe  = prev_cs_data & ~cs_data & ~bus_state;
    ctl_strobe = prev_cs_stat & ~cs_stat & ~bus_state;
    flush      = ctl_strobe & bus_wdata[0];
    ovf_clr    = ctl_strobe & bus_wdata[1];
    full       = (level == LEVEL_FULL);
    pop        = m_valid & m_ready;
    // A flush swallows a coincident push without counting it as an overflow.
    push_req   = wr_strobe & ~flush;
    // When full, a pop in the same cycle frees the slot the push lands in.
    push       = push_req & (~full | pop);
    drop       = push_req & full & ~pop;
  end

  // Next pointer / level / overflow state; flush overrides push and pop.
  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    level_nxt    = level;
    overflow_nxt = overflow;

    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      level_nxt  = '0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level_nxt = level + LEVEL_ONE;
        2'b01:   level_nxt = level - LEVEL_ONE;
        default: level_nxt = level;
      endcase
    end

    if (drop)    overflow_nxt = 1'b1;
    if (ovf_clr) overflow_nxt = 1'b0;
  end

  // Status word built from post-update state so reads see a change one cycle later.
  always_comb begin
    full_nxt    = (level_nxt == LEVEL_FULL);
    empty_nxt   = (level_nxt == '0);
    af_nxt      = (level_nxt >= LEVEL_AF);
    level_field = 12'(level_nxt);
    stat_nxt        = '0;
    stat_nxt[15:0]  = {overflow_nxt, full_nxt, empty_nxt, af_nxt, level_field};
    // The data slot reads as zero; everything else reads the status word.
    if (cs_data && !cs_stat) rdata_nxt = '0;
    else                     rdata_nxt = stat_nxt;
  end

  // Chip-select history; cleared by reset so an access cut by reset never strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cs_data <= 1'b0;
      prev_cs_stat <= 1'b0;
    end else begin
      prev_cs_data <= cs_data;
      prev_cs_stat <= cs_stat;
    end
  end

  // FIFO bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Stream valid tracks the registered occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) m_valid <= 1'b0;
    else       m_valid <= (level_nxt != '0);
  end

  // Bus read data is re-registered every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) bus_rdata <= STAT_RESET;
    else       bus_rdata <= rdata_nxt;
  end

  // Word storage write port.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus_wdata;
  end

  // First-word fall-through head of queue.
  always_comb begin
    m_data = mem[rd_ptr];
  end

`ifdef FSMC_TX_FIFO_IRQ_EN
  // Level interrupt from post-update almost-full and overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) irq <= 1'b0;
    else       irq <= af_nxt | overflow_nxt;
  end
`endif

endmodule

// File: tb/tb_fsmc_tx_fifo.sv
// Self-checking bench for fsmc_tx_fifo (DATA_WIDTH=16, DEPTH=64, AF_THRESHOLD=48).
// Irq checks are compiled in when FSMC_TX_FIFO_IRQ_EN is defined.
module tb_fsmc_tx_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 64;
  localparam int AF    = 48;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] bus_wdata = '0;
  logic          bus_state = 1'b0;
  logic          cs_data = 1'b0;
  logic          cs_stat = 1'b0;
  logic [DW-1:0] bus_rdata;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
`ifdef FSMC_TX_FIFO_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  fsmc_tx_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AF_THRESHOLD(AF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus_wdata (bus_wdata),
    .bus_state (bus_state),
    .cs_data   (cs_data),
    .cs_stat   (cs_stat),
    .bus_rdata (bus_rdata),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready)
`ifdef FSMC_TX_FIFO_IRQ_EN
    ,
    .irq       (irq)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Every stream transfer is compared against the oldest expected word.
  always @(negedge clk) begin
    if (!reset && m_valid && m_ready) begin
      if (exp_q.size() == 0) check("unexpected_pop", 32'(m_data), 32'hDEAD_0000);
      else                   check("m_data", 32'(m_data), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic write_data(input logic [DW-1:0] d);
    bus_state = 1'b0;
    bus_wdata = d;
    cs_data   = 1'b1;
    tick();
    cs_data = 1'b0;
    // Strobe cycle: the word is accepted if there is room or a pop frees a slot.
    if (exp_q.size() < DEPTH || m_ready) exp_q.push_back(d);
    tick();
  endtask

  task automatic ctl_write(input logic [DW-1:0] d);
    bus_state = 1'b0;
    bus_wdata = d;
    cs_stat   = 1'b1;
    tick();
    cs_stat = 1'b0;
    if (d[0]) exp_q.delete();
    tick();
  endtask

  task automatic check_stat(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check(tag, 32'(bus_rdata), 32'(exp));
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) write_data(DW'($urandom_range(0, 16'hFFFF)));
  endtask

  task automatic drain(input string tag);
    m_ready = 1'b1;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    m_ready = 1'b0;
    tick();
    check(tag, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_rdata", 32'(bus_rdata), 32'h2000);
    reset = 1'b0;
    tick();
    check_stat("idle_stat", 16'h2000);

    // Test 1: overflow set and level 5, then reset with a pending cs edge
    fill_random(DEPTH + 1);
    check_stat("t1_full_ovf", 16'hD040);
    ctl_write(16'h0001);
    check_stat("t1_flush_keep_ovf", 16'hA000);
    fill_random(5);
    check_stat("t1_lvl5_ovf", 16'h8005);
    bus_wdata = 16'h5A5A;
    cs_data   = 1'b1;
    tick();
    reset = 1'b1;
    #2;
    check("t1_async_valid", 32'(m_valid), 32'd0);
    check("t1_async_rdata", 32'(bus_rdata), 32'h2000);
    exp_q.delete();
    cs_data = 1'b0;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("t1_no_spurious", 32'(m_valid), 32'd0);
    check_stat("t1_post_rst_stat", 16'h2000);

    // Test 2: three words held, then streamed on consecutive cycles
    write_data(16'h1111);
    write_data(16'h2222);
    write_data(16'h3333);
    check_stat("t2_lvl3", 16'h0003);
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_valid_run", 32'(m_valid), 32'd1);
    end
    @(negedge clk);
    check("t2_valid_done", 32'(m_valid), 32'd0);
    check("t2_stat_empty", 32'(bus_rdata), 32'h2000);
    tick();
    m_ready = 1'b0;

    // Reads are side-effect free; data slot reads zero, status slot reads status
    write_data(16'h0A0A);
    bus_state = 1'b1;
    cs_data   = 1'b1;
    tick();
    @(negedge clk);
    check("rd_data_slot", 32'(bus_rdata), 32'd0);
    cs_data = 1'b0;
    tick();
    cs_stat = 1'b1;
    tick();
    @(negedge clk);
    check("rd_stat_slot", 32'(bus_rdata), 32'h0001);
    cs_stat = 1'b0;
    tick();
    tick();
    bus_state = 1'b0;
    check_stat("rd_no_effect", 16'h0001);
    drain("rd_drain");

    // Test 3: overflow on the 65th word, clear overflow, drain in order
    fill_random(DEPTH + 1);
    check_stat("t3_ovf", 16'hD040);
    ctl_write(16'h0002);
    check_stat("t3_ovf_clr", 16'h5040);
    drain("t3_drain");
    check_stat("t3_empty", 16'h2000);

    // Test 4: push while full with a simultaneous pop
    fill_random(DEPTH);
    check_stat("t4_full", 16'h5040);
    bus_wdata = 16'hC0DE;
    cs_data   = 1'b1;
    tick();
    cs_data = 1'b0;
    m_ready = 1'b1;
    exp_q.push_back(16'hC0DE);
    tick();
    m_ready = 1'b0;
    check_stat("t4_full_no_ovf", 16'h5040);
    drain("t4_drain");

    // Test 5: flush at level 10, then a fresh word comes out first
    fill_random(10);
    check_stat("t5_lvl10", 16'h000A);
    ctl_write(16'h0001);
    check("t5_flush_valid", 32'(m_valid), 32'd0);
    check_stat("t5_flush_stat", 16'h2000);
    write_data(16'hBEEF);
    @(negedge clk);
    check("t5_head", 32'(m_data), 32'hBEEF);
    drain("t5_drain");

`ifdef FSMC_TX_FIFO_IRQ_EN
    // Test 6: irq at the almost-full threshold
    fill_random(AF - 1);
    @(negedge clk);
    check("t6_irq_47", 32'(irq), 32'd0);
    write_data(16'h4848);
    @(negedge clk);
    check("t6_irq_48", 32'(irq), 32'd1);
    check("t6_stat_48", 32'(bus_rdata), 32'h1030);
    tick();
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    @(negedge clk);
    check("t6_irq_47_again", 32'(irq), 32'd0);
    drain("t6_drain");
`endif

    check_stat("final_stat", 16'h2000);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
